// File: rtl/arb_pkg.sv
// Shared types and defaults for the round-robin arbiter slice.
// The hold-limit feature is selected by the RR_ARB_HOLD_LIMIT_EN macro.
package arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  localparam int DEF_NUM_REQ  = 4;
  localparam int DEF_MAX_HOLD = 8;

  // hold_cnt is sized for the largest legal MAX_HOLD (255)
  localparam int HOLD_CNT_W   = 8;

endpackage

// File: rtl/rr_arbiter_if.sv
// Requester-side bundle of the round-robin arbiter.
// The master modport is the requester side and the slave modport is the arbiter.
interface rr_arbiter_if
  import arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] grant;
  logic               grant_valid;
  logic [ID_W-1:0]    grant_id;
  logic               hold_expired;

  modport master (
    output req,
    input  grant,
    input  grant_valid,
    input  grant_id,
    input  hold_expired
  );

  modport slave (
    input  req,
    output grant,
    output grant_valid,
    output grant_id,
    output hold_expired
  );

endinterface

// File: rtl/rr_arbiter_pick.sv
// Combinational round-robin picker: the first set bit of req_mask at or after ptr, wrapping.
// It returns a found flag, the winner index and the one-hot winner.
module rr_pick
  import arb_pkg::*;
#(
  parameter  int NUM_REQ = DEF_NUM_REQ,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_mask,
  input  logic [ID_W-1:0]    ptr,
  output logic               found,
  output logic [ID_W-1:0]    winner_id,
  output logic [NUM_REQ-1:0] winner_onehot
);

  logic [NUM_REQ-1:0] rot_req;
  logic [ID_W-1:0]    rot_idx [NUM_REQ];

  // rot_req[gi] is the request that sits gi positions after ptr in search order
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
    logic [ID_W:0] sum;
    assign sum          = {1'b0, ptr} + (ID_W+1)'(gi);
    assign rot_idx[gi]  = (sum >= (ID_W+1)'(NUM_REQ)) ? ID_W'(sum - (ID_W+1)'(NUM_REQ))
                                                      : sum[ID_W-1:0];
    assign rot_req[gi]  = req_mask[rot_idx[gi]];
  end

  always_comb begin
    found     = 1'b0;
    winner_id = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot_req[i]) begin
        found     = 1'b1;
        winner_id = rot_idx[i];
      end
    end
  end

  always_comb begin
    winner_onehot = '0;
    if (found) begin
      winner_onehot[winner_id] = 1'b1;
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with registered one-hot grant and hold-while-asserted ownership.
// Defining RR_ARB_HOLD_LIMIT_EN adds forced rotation after MAX_HOLD cycles when others wait.
module rr_arbiter
  import arb_pkg::*;
#(
  parameter  int NUM_REQ  = DEF_NUM_REQ,
  parameter  int MAX_HOLD = DEF_MAX_HOLD,
  localparam int ID_W     = $clog2(NUM_REQ)
) (
  input  logic         clock,
  input  logic         reset,
  rr_arbiter_if.slave  bus
);

  arb_state_t         state_reg, state_next;
  logic [ID_W-1:0]    ptr_reg, ptr_next;
  logic [NUM_REQ-1:0] grant_reg, grant_next;
  logic [ID_W-1:0]    grant_id_reg, grant_id_next;
  logic               grant_valid_reg, grant_valid_next;
  logic               hold_expired_reg, hold_expired_next;

  logic               holder_req;
  logic               others_req;
  logic               force_rot;
  logic [NUM_REQ-1:0] pick_mask;
  logic               pick_found;
  logic [ID_W-1:0]    pick_id;
  logic [NUM_REQ-1:0] pick_onehot;

  assign holder_req = |(bus.req & grant_reg);
  assign others_req = |(bus.req & ~grant_reg);

`ifdef RR_ARB_HOLD_LIMIT_EN
  localparam logic [HOLD_CNT_W-1:0] HOLD_LAST = HOLD_CNT_W'(MAX_HOLD - 1);

  logic [HOLD_CNT_W-1:0] hold_cnt_reg, hold_cnt_next;

  assign force_rot = (state_reg == GRANT) && holder_req && others_req &&
                     (hold_cnt_reg == HOLD_LAST);
`else
  assign force_rot = 1'b0;
`endif

  // A forced rotation must not hand the grant straight back to the current holder
  assign pick_mask = force_rot ? (bus.req & ~grant_reg) : bus.req;

  rr_pick #(
    .NUM_REQ(NUM_REQ)
  ) u_pick (
    .req_mask      (pick_mask),
    .ptr           (ptr_reg),
    .found         (pick_found),
    .winner_id     (pick_id),
    .winner_onehot (pick_onehot)
  );

  always_comb begin
    logic new_grant;
    new_grant         = 1'b0;
    state_next        = state_reg;
    ptr_next          = ptr_reg;
    grant_next        = grant_reg;
    grant_id_next     = grant_id_reg;
    hold_expired_next = 1'b0;
`ifdef RR_ARB_HOLD_LIMIT_EN
    hold_cnt_next     = hold_cnt_reg;
`endif

    unique case (state_reg)
      IDLE: begin
        if (pick_found) begin
          new_grant = 1'b1;
        end
      end
      GRANT: begin
        if (force_rot) begin
          new_grant         = 1'b1;
          hold_expired_next = 1'b1;
        end else if (holder_req) begin
`ifdef RR_ARB_HOLD_LIMIT_EN
          if (hold_cnt_reg != HOLD_LAST) begin
            hold_cnt_next = hold_cnt_reg + HOLD_CNT_W'(1);
          end
`endif
        end else if (pick_found) begin
          new_grant = 1'b1;
        end else begin
          state_next    = IDLE;
          grant_next    = '0;
          grant_id_next = '0;
        end
      end
      default: begin
        state_next    = IDLE;
        grant_next    = '0;
        grant_id_next = '0;
      end
    endcase

    if (new_grant) begin
      state_next    = GRANT;
      grant_next    = pick_onehot;
      grant_id_next = pick_id;
      ptr_next      = (pick_id == ID_W'(NUM_REQ - 1)) ? '0 : pick_id + ID_W'(1);
`ifdef RR_ARB_HOLD_LIMIT_EN
      hold_cnt_next = '0;
`endif
    end

    grant_valid_next = |grant_next;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg        <= IDLE;
      ptr_reg          <= '0;
      grant_reg        <= '0;
      grant_id_reg     <= '0;
      grant_valid_reg  <= 1'b0;
      hold_expired_reg <= 1'b0;
    end else begin
      state_reg        <= state_next;
      ptr_reg          <= ptr_next;
      grant_reg        <= grant_next;
      grant_id_reg     <= grant_id_next;
      grant_valid_reg  <= grant_valid_next;
      hold_expired_reg <= hold_expired_next;
    end
  end

`ifdef RR_ARB_HOLD_LIMIT_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      hold_cnt_reg <= '0;
    end else begin
      hold_cnt_reg <= hold_cnt_next;
    end
  end
`endif

  assign bus.grant        = grant_reg;
  assign bus.grant_id     = grant_id_reg;
  assign bus.grant_valid  = grant_valid_reg;
  assign bus.hold_expired = hold_expired_reg;

endmodule

// File: tb/tb_rr_arbiter.sv
// Scoreboard bench for rr_arbiter: directed req vectors push the expected grant for the
// following edge; a monitor pops and checks each cycle on the falling edge.
module tb_rr_arbiter;
  import arb_pkg::*;

  localparam int N = 4;

  typedef struct {
    int         cyc;
    logic [3:0] g;
    logic       he;
  } exp_t;

  logic clock;
  logic reset;
  int   cyc;
  int   total;
  int   bad;
  exp_t exp_q[$];

  rr_arbiter_if #(.NUM_REQ(N)) bus ();

  rr_arbiter #(
    .NUM_REQ  (N),
    .MAX_HOLD (8)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic step(input logic r, input logic [3:0] rq, input logic [3:0] eg, input logic eh);
    exp_t e;
    @(posedge clock);
    #1;
    reset   = r;
    bus.req = rq;
    e.cyc   = cyc + 1;
    e.g     = eg;
    e.he    = eh;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input int act, input int req_val);
    total++;
    if (act !== req_val) begin
      bad++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req_val);
    end
  endtask

  // Monitor: one line per checked transaction
  always @(negedge clock) begin
    if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      exp_t e;
      int   eid;
      e   = exp_q.pop_front();
      eid = 0;
      for (int i = 0; i < N; i++) if (e.g[i]) eid = i;
      if (e.cyc != cyc) check("stale_expect", cyc, e.cyc);
      check("grant", int'(bus.grant), int'(e.g));
      check("grant_id", int'(bus.grant_id), eid);
      check("grant_valid", int'(bus.grant_valid), int'(|e.g));
      check("hold_expired", int'(bus.hold_expired), int'(e.he));
      $display("cyc=%0d req=%b grant=%b exp=%b id=%0d he=%b", cyc, bus.req, bus.grant, e.g,
               bus.grant_id, bus.hold_expired);
    end
  end

  initial begin
    int wait_cnt;
    total   = 0;
    bad     = 0;
    reset   = 1'b1;
    bus.req = '0;

    // Reset with all requests held, then first grant to 0
    step(1'b1, 4'b1111, 4'b0000, 1'b0);
    step(1'b1, 4'b1111, 4'b0000, 1'b0);
    step(1'b0, 4'b1111, 4'b0001, 1'b0);
    repeat (3) step(1'b0, 4'b1111, 4'b0001, 1'b0);
    // Holder 0 releases, search from 1
    step(1'b0, 4'b1110, 4'b0010, 1'b0);
    step(1'b0, 4'b0000, 4'b0000, 1'b0);
    // Single-cycle pulse on 2, then ptr=3 favours 3
    step(1'b0, 4'b0100, 4'b0100, 1'b0);
    step(1'b0, 4'b0000, 4'b0000, 1'b0);
    step(1'b0, 4'b1111, 4'b1000, 1'b0);
    step(1'b0, 4'b0000, 4'b0000, 1'b0);
    // Holder 2 drops with 0 and 3 waiting: 3 wins
    step(1'b0, 4'b0100, 4'b0100, 1'b0);
    step(1'b0, 4'b1101, 4'b0100, 1'b0);
    step(1'b0, 4'b1001, 4'b1000, 1'b0);
    // Holder 1 drops then rises again; it must wait its turn
    step(1'b0, 4'b0110, 4'b0010, 1'b0);
    step(1'b0, 4'b0101, 4'b0100, 1'b0);
    step(1'b0, 4'b0111, 4'b0100, 1'b0);
    step(1'b0, 4'b0011, 4'b0001, 1'b0);
    // Reset mid-grant returns ptr to 0 (ptr was 1, would pick 3)
    step(1'b0, 4'b0011, 4'b0001, 1'b0);
    step(1'b1, 4'b1001, 4'b0000, 1'b0);
    step(1'b0, 4'b1001, 4'b0001, 1'b0);
    step(1'b0, 4'b0000, 4'b0000, 1'b0);
    step(1'b1, 4'b0000, 4'b0000, 1'b0);

`ifdef RR_ARB_HOLD_LIMIT_EN
    // All requesting: each holder gets 8 cycles, forced rotation pulses hold_expired
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 8; c++) begin
        logic [3:0] g;
        g = 4'b0001 << (r % 4);
        step(1'b0, 4'b1111, g, (r > 0 && c == 0));
      end
    end
    step(1'b0, 4'b0000, 4'b0000, 1'b0);
    // Lone holder 1 keeps the grant well past MAX_HOLD
    for (int c = 0; c < 20; c++) step(1'b0, 4'b0010, 4'b0010, 1'b0);
    step(1'b0, 4'b0000, 4'b0000, 1'b0);
`else
    // Without the limit the first winner keeps the grant indefinitely
    for (int c = 0; c < 50; c++) step(1'b0, 4'b1111, 4'b0001, 1'b0);
    step(1'b0, 4'b1110, 4'b0010, 1'b0);
    step(1'b0, 4'b0000, 4'b0000, 1'b0);
`endif

    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 20) begin
      @(posedge clock);
      wait_cnt++;
    end
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    @(posedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rr_arbiter.md
# rr_arbiter

Round-robin arbiter that shares one resource among NUM_REQ requesters with registered one-hot grants. It extends the team's two-requester hold-while-asserted arbiter to N requesters, adding fair rotation and an optional hold limit. It sits between the requester-side interfaces and the shared resource's select/enable logic.

## Interface
- NUM_REQ, 4: number of requesters, 2..16
- MAX_HOLD, 8: maximum consecutive grant cycles while others wait, 2..255; used only with the hold-limit feature
- clock  input  1  rising-edge clock
- reset  input  1  reset, synchronous, active-high
- req  input  NUM_REQ  per-requester request, level-sensitive
- grant  output  NUM_REQ  one-hot registered grant, all-zero when idle
- grant_valid  output  1  OR of grant
- grant_id  output  $clog2(NUM_REQ)  index of the granted requester, 0 when idle
- hold_expired  output  1  one-cycle pulse on the edge where a grant is forcibly rotated

## Operation
- States: IDLE (no grant), GRANT (one requester owns the resource).
- Round-robin pointer `ptr` holds the highest-priority index. Search order is ptr, ptr+1, …, NUM_REQ-1, 0, …, ptr-1, with modulo wrap.
- IDLE:
  - If any req is set, grant the first set bit in search order and go to GRANT.
  - Otherwise stay in IDLE.
- GRANT, while the holder's req stays high:
  - Keep the grant.
  - hold_cnt increments, saturating at MAX_HOLD-1.
- GRANT, holder drops req:
  - If another req is set, hand over on the same edge to the next winner in search order. No idle bubble.
  - Otherwise go to IDLE.
- Hold limit (only when compiled in):
  - Trigger: hold_cnt == MAX_HOLD-1, the holder's req is high, and any other req is high.
  - Action: grant moves to the next winner, excluding the holder. hold_expired pulses for one cycle.
  - If no other requester is waiting, the holder keeps the grant and hold_cnt saturates.
- On every new grant to index i:
  - ptr ← (i+1) mod NUM_REQ.
  - hold_cnt ← 0.
- At most one grant bit is ever set. grant is never asserted to a requester whose req was low at the deciding edge.
- Reset values: state=IDLE, ptr=0, hold_cnt=0, grant=0, grant_valid=0, grant_id=0, hold_expired=0.
- Reset mid-grant: grant drops on the next edge. The pointer returns to 0.

## Timing
- All outputs are registered. req sampled at edge t takes effect in grant after edge t.
- Request-to-grant latency from IDLE is 1 cycle.
- Release-to-handover latency is 1 cycle.
- Forced rotation happens at the edge that ends the MAX_HOLD-th granted cycle. The holder owns the resource for exactly MAX_HOLD cycles.
- When all req bits are set and every holder keeps req high (limit enabled), each requester gets MAX_HOLD cycles in the order 0,1,…,NUM_REQ-1,0.
- A holder whose req drops and rises again in the next cycle must re-arbitrate. It wins only in its round-robin turn.

## Configuration
- RR_ARB_HOLD_LIMIT_EN defined:
  - hold_cnt and the forced rotation are present.
  - hold_expired is driven as specified above.
- RR_ARB_HOLD_LIMIT_EN undefined:
  - No counter. A holder keeps the grant for as long as its req stays high.
  - hold_expired is tied to 0.
  - MAX_HOLD is ignored.

## Structure
- Shared package arb_pkg:
  - arb_state_t enum (IDLE, GRANT)
  - default NUM_REQ and MAX_HOLD constants
  - a log2 helper function, if the tool flow needs one
- Sub-module rr_pick:
  - Combinational.
  - Inputs: req mask, ptr.
  - Outputs: found, winner index, one-hot winner.
  - Instantiated once. The exclude-holder mask is applied by the parent.

## Test plan
- Reset with req=4'b1111 held → grant=0 during reset. First edge after reset deasserts → grant=4'b0001, grant_id=0.
- req=4'b0100 single pulse, 1 cycle → grant=4'b0100 for exactly 1 cycle, then IDLE. ptr=3, checked by next req=4'b1111 → grant=4'b1000.
- req=4'b1111 held, MAX_HOLD=8, limit enabled → grant rotates 0001→0010→0100→1000→0001, each held 8 cycles. hold_expired pulses at each rotation.
- Holder 1 alone requesting for 20 cycles (limit enabled) → grant=4'b0010 held all 20 cycles. hold_expired stays 0.
- Holder 2 drops req while req[0] and req[3] are set → next cycle grant=4'b1000, since search starts at 3.
- Reset asserted mid-grant at cycle 5 → all outputs 0 after the edge. Re-arbitration starts from ptr=0.
- Build without RR_ARB_HOLD_LIMIT_EN, req=4'b1111 held 50 cycles → grant=4'b0001 throughout. hold_expired stays 0.
